lc3_writeback_responder: RTL

- Consuming end of the writeback_in bus: the LC3 Writeback stage that the writeback_in initiator agent drives.
- Selects the writeback value from aluout/memout/pcout/npc under W_control_in.
- Holds the 8-entry general-purpose register file and the NZP condition codes (psr).
- Returns two source-register read values (d1/d2) to Execute and counts completed writebacks for coverage and debug.

---
 rtl/lc3_writeback_responder.sv | 72 +++++++
 1 files changed

// File: rtl/lc3_writeback_responder.sv
// LC3 Writeback stage: selects the writeback value, owns the register file, NZP codes and commit counter.
// Optional write-through forwarding of the committing value to d1/d2 is enabled by defining WB_BYPASS_EN.
module lc3_writeback_responder #(
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_REGS   = 8,
   parameter  int CNT_WIDTH  = 16,
   localparam int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable_writeback,
   input  logic [DATA_WIDTH-1:0] npc,
   input  logic [1:0]            W_control_in,
   input  logic [DATA_WIDTH-1:0] aluout,
   input  logic [DATA_WIDTH-1:0] pcout,
   input  logic [DATA_WIDTH-1:0] memout,
   input  logic [IDX_W-1:0]      sr1,
   input  logic [IDX_W-1:0]      sr2,
   input  logic [IDX_W-1:0]      dr,
   output logic [DATA_WIDTH-1:0] d1,
   output logic [DATA_WIDTH-1:0] d2,
   output logic [2:0]            psr,
   output logic [DATA_WIDTH-1:0] wb_value,
   output logic [CNT_WIDTH-1:0]  wb_count
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [2:0]            next_psr;

   // A full case keeps unselected (possibly X) sources out of the result.
   always_comb begin
      wb_value = aluout;
      unique case (W_control_in)
         2'd0: wb_value = aluout;
         2'd1: wb_value = memout;
         2'd2: wb_value = pcout;
         2'd3: wb_value = npc;
      endcase
   end

   always_comb begin
      if (wb_value[DATA_WIDTH-1])
         next_psr = 3'b100;
      else if (wb_value == '0)
         next_psr = 3'b010;
      else
         next_psr = 3'b001;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         psr      <= 3'b000;
         wb_count <= '0;
      end else if (enable_writeback) begin
         regs[dr] <= wb_value;
         psr      <= next_psr;
         wb_count <= wb_count + 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   // Forward the value being committed so Execute sees it in the same cycle.
   assign d1 = (enable_writeback && (sr1 == dr)) ? wb_value : regs[sr1];
   assign d2 = (enable_writeback && (sr2 == dr)) ? wb_value : regs[sr2];
`else
   assign d1 = regs[sr1];
   assign d2 = regs[sr2];
`endif

endmodule
